xgriscv_run_ctrl: RTL and testbench
===================================

Name: xgriscv_run_ctrl

Overview:
Synthesizable run controller that drives the pipelined core's reset and watches its PC stream. It provides the stimulus side of the core's run interface: it holds the core in reset, releases it, and counts run cycles. It detects end-of-program when PC equals a halt address. It also flags failure on cycle timeout or a stuck PC, and lets the program run on FPGA without a simulation testbench.

Parameters:
ADDR_SIZE, 32, width of pc, halt_addr and last_pc.
CNT_W, 32, width of cycle_cnt.
RST_CYCLES, 4, number of cycles the core reset is held after start (must be ≥1).
MAX_CYCLES, 100000, RUN-cycle budget before timeout (must be ≥2).
STUCK_LIMIT, 16, consecutive repeated-PC cycles that declare the core stuck (must be ≥1).

Ports:
clk  in  1  system clock; all logic on rising edge.
rstn  in  1  reset, synchronous, active-high; named rstn as in the codebase.
start  in  1  one-cycle pulse that launches a run from IDLE, DONE or FAIL.
halt_addr  in  ADDR_SIZE  address of the last instruction; sampled every RUN cycle.
pc  in  ADDR_SIZE  current PC from the core.
cpu_rstn  out  1  reset to the core, active-high (1 = hold core in reset).
running  out  1  high while in RUN.
done  out  1  program reached halt_addr.
timeout  out  1  MAX_CYCLES exhausted.
stuck  out  1  PC unchanged for STUCK_LIMIT cycles.
cycle_cnt  out  CNT_W  number of RUN cycles of the current or last run.
last_pc  out  ADDR_SIZE  PC sampled on the most recent RUN cycle.

Behaviour:
- Reset (rstn=1 at an edge): state=IDLE, cpu_rstn=1, running/done/timeout/stuck=0, cycle_cnt=0, last_pc=0, internal counters=0. Reset has priority over every event, including mid-RUN.
- States: IDLE, RESET, RUN, DONE, FAIL. All outputs are registered.
- IDLE: cpu_rstn=1. start → RESET; rst_cnt=RST_CYCLES-1.
- RESET: cpu_rstn=1, flags cleared, cycle_cnt=0. rst_cnt decrements each cycle. When rst_cnt=0, go to RUN and set cpu_rstn=0. cpu_rstn is therefore high for exactly RST_CYCLES cycles after the start edge.
- RUN, evaluated at each edge:
  - cycle_cnt+1 is the count including this cycle.
  - last_pc<=pc.
  - stuck_cnt: on the first RUN cycle, stuck_cnt=0. On later cycles it increments if pc==last_pc and clears to 0 otherwise.
- RUN exits, in priority order:
  - pc==halt_addr → DONE, done=1.
  - Else, not the first cycle and pc==last_pc and stuck_cnt+1==STUCK_LIMIT → FAIL, stuck=1.
  - Else cycle_cnt+1==MAX_CYCLES → FAIL, timeout=1.
  - cycle_cnt is updated on the exit edge too, so it equals the total RUN cycles.
- DONE/FAIL: cpu_rstn=1 (core parked), running=0. Flags, cycle_cnt and last_pc hold. start → RESET and clears flags.
- start in RESET or RUN is ignored.
- At most one of done/timeout/stuck is high at any time.
- cycle_cnt never wraps, because MAX_CYCLES must not exceed 2^CNT_W-1.

Test Plan:
1. Halt: halt_addr=0x1c; after start, pc steps 0x00,0x04,…,0x1c, one per RUN cycle → cpu_rstn high for 4 cycles. DONE is reached after the 8th RUN cycle with done=1, cycle_cnt=8, last_pc=0x1c, cpu_rstn=1, running=0.
2. Timeout: MAX_CYCLES=20, pc increments by 4 and never reaches halt_addr=0x1000 → timeout=1, cycle_cnt=20, stuck=0, done=0.
3. Stuck: pc held at 0x10, halt_addr=0x1c, STUCK_LIMIT=16 → stuck=1 after RUN cycle 17 with cycle_cnt=17. A variant where pc changes at cycle 10 restarts the count, so FAIL occurs at cycle 26.
4. Priority: pc stuck at 0x1c equal to halt_addr → done=1 on RUN cycle 1, stuck=0. With MAX_CYCLES=2 and halt reached on cycle 2 → done=1, timeout=0.
5. Reset mid-run: assert rstn at RUN cycle 5 → next cycle IDLE, cpu_rstn=1, cycle_cnt=0, all flags 0. A start pulse during RUN has no effect.
6. Restart: from DONE, pulse start → done clears on the next edge, cpu_rstn high 4 cycles, and a second run of test 1 yields cycle_cnt=8 again.

Source files
------------

// File: rtl/xgriscv_run_ctrl.sv
// xgriscv_run_ctrl: holds the core in reset, releases it, then watches its PC for halt, timeout or stuck.
//   clk_i        rising-edge clock
//   rstn_i       synchronous reset, active-high
//   start_i      launch pulse, honoured in IDLE, DONE and FAIL
//   halt_addr_i  address whose arrival ends the program
//   pc_i         PC stream from the core
//   cpu_rstn_o   core reset, active-high
//   running_o    high while the core runs
//   done_o       halt address reached
//   timeout_o    run-cycle budget exhausted
//   stuck_o      PC repeated for STUCK_LIMIT cycles
//   cycle_cnt_o  RUN cycles of the current or last run
//   last_pc_o    PC seen on the most recent RUN cycle
module xgriscv_run_ctrl #(
    parameter int ADDR_SIZE   = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int MAX_CYCLES  = 100000,
    parameter int STUCK_LIMIT = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic [ADDR_SIZE-1:0] halt_addr_i,
    input  logic [ADDR_SIZE-1:0] pc_i,
    output logic                 cpu_rstn_o,
    output logic                 running_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 stuck_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [ADDR_SIZE-1:0] last_pc_o
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STUCK_LIMIT + 1);
    typedef enum logic [2:0] {IDLE, RESET, RUN, DONE, FAIL} state_t;
    state_t               state_q;
    logic [RW-1:0]        rst_cnt_q;
    logic [SW-1:0]        stuck_cnt_q, stuck_cnt_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [ADDR_SIZE-1:0] last_pc_q;
    logic                 first_q, cpu_rstn_q, running_q, done_q, timeout_q, stuck_q;
    logic                 same_pc, hit_halt, hit_stuck, hit_max;
    // last_pc_q still holds the previous run's PC on the first RUN cycle, so the first cycle never counts as a repeat
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        same_pc     = !first_q && pc_i == last_pc_q;
        stuck_cnt_d = same_pc ? stuck_cnt_q + SW'(1) : '0;
        hit_halt    = pc_i == halt_addr_i;
        hit_stuck   = same_pc && 32'(stuck_cnt_d) == STUCK_LIMIT;
        hit_max     = 32'(cycle_cnt_d) == MAX_CYCLES;
    end
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            stuck_cnt_q <= '0;
            cycle_cnt_q <= '0;
            last_pc_q   <= '0;
            first_q     <= 1'b0;
            cpu_rstn_q  <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, FAIL: begin
                    if (start_i) begin
                        state_q     <= RESET;
                        rst_cnt_q   <= RW'(RST_CYCLES - 1);
                        stuck_cnt_q <= '0;
                        cycle_cnt_q <= '0;
                        cpu_rstn_q  <= 1'b1;
                        done_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        stuck_q     <= 1'b0;
                    end
                end
                RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_q    <= RUN;
                        first_q    <= 1'b1;
                        cpu_rstn_q <= 1'b0;
                        running_q  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RW'(1);
                    end
                end
                RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    last_pc_q   <= pc_i;
                    stuck_cnt_q <= stuck_cnt_d;
                    first_q     <= 1'b0;
                    if (hit_halt || hit_stuck || hit_max) begin
                        state_q    <= hit_halt ? DONE : FAIL;
                        cpu_rstn_q <= 1'b1;
                        running_q  <= 1'b0;
                        done_q     <= hit_halt;
                        stuck_q    <= !hit_halt && hit_stuck;
                        timeout_q  <= !hit_halt && !hit_stuck;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cpu_rstn_o  = cpu_rstn_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign stuck_o     = stuck_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign last_pc_o   = last_pc_q;
endmodule

// File: tb/tb_xgriscv_run_ctrl.sv
// tb_xgriscv_run_ctrl: drives PC sequences into the run controller and compares against a cycle-list model.
module tb_xgriscv_run_ctrl;
    localparam int RSTC = 4;
    localparam int MAXC = 30;
    localparam int SL   = 16;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic [31:0] halt_addr = '0;
    logic [31:0] pc = '0;
    logic        cpu_rstn, running, done, timeout, stuck;
    logic [31:0] cycle_cnt, last_pc;
    logic [31:0] pcs [1:64];
    int          n_chk = 0;
    int          n_fail = 0;
    always #5 clk = ~clk;
    xgriscv_run_ctrl #(
        .ADDR_SIZE(32), .CNT_W(32), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .STUCK_LIMIT(SL)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .halt_addr_i(halt_addr), .pc_i(pc),
        .cpu_rstn_o(cpu_rstn), .running_o(running), .done_o(done), .timeout_o(timeout),
        .stuck_o(stuck), .cycle_cnt_o(cycle_cnt), .last_pc_o(last_pc)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [31:0] h);
        @(negedge clk);
        halt_addr = h;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("launch_flags", {done, timeout, stuck}, 0);
        check("launch_cnt", cycle_cnt, 0);
        for (int i = 0; i < RSTC; i++) begin
            check("cpu_rstn_hold", cpu_rstn, 1);
            check("running_in_reset", running, 0);
            start = (i == 1);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check("cpu_rstn_release", cpu_rstn, 0);
        check("running_on", running, 1);
    endtask
    task automatic run_check(input logic [31:0] h);
        int kind, n, rs;
        kind = 0;
        n = 0;
        rs = 1;
        for (int k = 1; k <= 64 && kind == 0; k++) begin
            if (k > 1 && pcs[k] != pcs[k-1]) rs = k;
            if (pcs[k] == h) kind = 1;
            else if (k - rs == SL) kind = 2;
            else if (k == MAXC) kind = 3;
            n = k;
        end
        launch(h);
        for (int k = 1; k <= n; k++) begin
            pc = pcs[k];
            @(posedge clk);
            @(negedge clk);
            check("cycle_cnt", cycle_cnt, k);
            check("last_pc", last_pc, pcs[k]);
            check("running", running, k < n);
        end
        check("done", done, kind == 1);
        check("stuck", stuck, kind == 2);
        check("timeout", timeout, kind == 3);
        check("cpu_rstn_parked", cpu_rstn, 1);
        pc = pcs[n] + 32'd4;
        @(posedge clk);
        @(negedge clk);
        check("cnt_hold", cycle_cnt, n);
        check("last_pc_hold", last_pc, pcs[n]);
        check("flags_hold", {done, stuck, timeout}, {kind == 1, kind == 2, kind == 3});
        check("running_parked", running, 0);
    endtask
    initial begin
        int thr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cpu_rstn", cpu_rstn, 1);
        check("reset_flags", {running, done, timeout, stuck}, 0);
        check("reset_cnt", cycle_cnt, 0);
        check("reset_last_pc", last_pc, 0);
        rstn = 1'b0;
        for (int k = 1; k <= 64; k++) pcs[k] = 32'((k - 1) * 4);
        run_check(32'h1c);
        run_check(32'h1c);
        for (int k = 1; k <= 64; k++) pcs[k] = 32'(k * 4);
        run_check(32'h1000);
        for (int k = 1; k <= 64; k++) pcs[k] = 32'h10;
        run_check(32'h1c);
        for (int k = 1; k <= 64; k++) pcs[k] = k < 10 ? 32'h10 : 32'h14;
        run_check(32'h1c);
        for (int k = 1; k <= 64; k++) pcs[k] = 32'h1c;
        run_check(32'h1c);
        for (int k = 1; k <= 64; k++) pcs[k] = 32'((k - 1) * 4);
        run_check(32'((MAXC - 1) * 4));
        for (int it = 0; it < 12; it++) begin
            thr = int'($urandom_range(0, 10));
            pcs[1] = 32'($urandom_range(0, 7) * 4);
            for (int k = 2; k <= 64; k++)
                pcs[k] = (int'($urandom_range(0, 9)) < thr) ? pcs[k-1] : 32'($urandom_range(0, 7) * 4);
            run_check(32'($urandom_range(0, 31) * 4));
        end
        for (int k = 1; k <= 64; k++) pcs[k] = 32'(k * 4);
        launch(32'h1000);
        for (int k = 1; k <= 5; k++) begin
            pc = pcs[k];
            start = (k == 3);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check("midrun_start_ignored", {running, cpu_rstn}, 2'b10);
        check("midrun_cnt", cycle_cnt, 5);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        check("midrun_rst_cpu_rstn", cpu_rstn, 1);
        check("midrun_rst_flags", {running, done, timeout, stuck}, 0);
        check("midrun_rst_cnt", cycle_cnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_stays", {cpu_rstn, running}, 2'b10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
